// File: rtl/cw_decoder.sv
// Constant-weight word decoder: turns t gap values back into the message bit stream (d = 2^u split).
// Latency: 2-cycle best_d query per symbol, then one bit per accepted transfer; one-cycle commit per gap.
// Backpressure: bit_out holds while bit_valid && !bit_ready; delta_ready only in FETCH, one gap per fetch.
module cw_decoder #(
    parameter int NW = 21,
    parameter int TW = 4,
    parameter int UW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [NW-1:0] n_in,
    input  logic [TW-1:0] t_in,
    output logic [NW-1:0] bd_n,
    output logic [TW-1:0] bd_t,
    input  logic [UW-1:0] bd_u,
    input  logic [NW-1:0] delta_in,
    input  logic          delta_valid,
    output logic          delta_ready,
    output logic          bit_out,
    output logic          bit_valid,
    input  logic          bit_ready,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [NW-1:0] bit_count
);

    typedef enum logic [3:0] {
        st_idle, st_query, st_fetch, st_cmp, st_emit1,
        st_emit0, st_emitb, st_commit, st_done, st_err
    } state_t;

    state_t        st, st_nxt;
    logic [NW-1:0] n, n_nxt;
    logic [TW-1:0] t, t_nxt;
    logic [NW-1:0] dl, dl_nxt;
    logic [NW-1:0] d, d_nxt;
    logic [UW-1:0] u, u_nxt;
    logic [UW-1:0] idx, idx_nxt;
    logic          hold, hold_nxt;
    logic          qph, qph_nxt;
    logic [NW-1:0] cnt_nxt;
    logic          bv_nxt, bo_nxt, busy_nxt;
    logic          xfer;

    assign xfer        = bit_valid && bit_ready;
    assign delta_ready = (st == st_fetch);
    assign bd_n        = n;
    assign bd_t        = t;

    always_comb begin
        st_nxt   = st;
        n_nxt    = n;
        t_nxt    = t;
        dl_nxt   = dl;
        d_nxt    = d;
        u_nxt    = u;
        idx_nxt  = idx;
        hold_nxt = hold;
        qph_nxt  = 1'b0;
        cnt_nxt  = xfer ? bit_count + NW'(1) : bit_count;
        case (st)
            st_idle, st_done, st_err: begin
                if (start) begin
                    n_nxt    = n_in;
                    t_nxt    = t_in;
                    cnt_nxt  = '0;
                    hold_nxt = 1'b0;
                    st_nxt   = (t_in == '0) ? st_done : st_query;
                end else if (st == st_done) begin
                    st_nxt = st_idle;
                end
            end
            // first cycle presents n/t, second cycle samples the registered best_d answer
            st_query: begin
                if (!qph) begin
                    qph_nxt = 1'b1;
                end else begin
                    u_nxt  = bd_u;
                    d_nxt  = NW'(1) << bd_u;
                    st_nxt = hold ? st_cmp : st_fetch;
                end
            end
            st_fetch: begin
                if (delta_valid) begin
                    if (delta_in > n - NW'(t)) begin
                        st_nxt = st_err;
                    end else begin
                        dl_nxt   = delta_in;
                        hold_nxt = 1'b1;
                        st_nxt   = st_cmp;
                    end
                end
            end
            st_cmp: st_nxt = (dl >= d) ? st_emit1 : st_emit0;
            st_emit1: begin
                if (xfer) begin
                    dl_nxt = dl - d;
                    n_nxt  = n - d;
                    st_nxt = st_query;
                end
            end
            st_emit0: begin
                if (xfer) begin
                    if (u == '0) begin
                        st_nxt = st_commit;
                    end else begin
                        idx_nxt = u - UW'(1);
                        st_nxt  = st_emitb;
                    end
                end
            end
            st_emitb: begin
                if (xfer) begin
                    if (idx == '0) st_nxt = st_commit;
                    else           idx_nxt = idx - UW'(1);
                end
            end
            st_commit: begin
                n_nxt    = n - dl - NW'(1);
                t_nxt    = t - TW'(1);
                hold_nxt = 1'b0;
                st_nxt   = (t == TW'(1)) ? st_done : st_query;
            end
            default: st_nxt = st_idle;
        endcase

        // output bit is registered from the state being entered, so it stays put under backpressure
        bv_nxt = 1'b0;
        bo_nxt = 1'b0;
        case (st_nxt)
            st_emit1: begin bv_nxt = 1'b1; bo_nxt = 1'b1; end
            st_emit0: begin bv_nxt = 1'b1; bo_nxt = 1'b0; end
            st_emitb: begin bv_nxt = 1'b1; bo_nxt = dl_nxt[idx_nxt]; end
            default:  begin bv_nxt = 1'b0; bo_nxt = 1'b0; end
        endcase
        busy_nxt = !(st_nxt == st_idle || st_nxt == st_done || st_nxt == st_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= st_idle;
            n         <= '0;
            t         <= '0;
            dl        <= '0;
            d         <= '0;
            u         <= '0;
            idx       <= '0;
            hold      <= 1'b0;
            qph       <= 1'b0;
            bit_count <= '0;
            bit_valid <= 1'b0;
            bit_out   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            st        <= st_nxt;
            n         <= n_nxt;
            t         <= t_nxt;
            dl        <= dl_nxt;
            d         <= d_nxt;
            u         <= u_nxt;
            idx       <= idx_nxt;
            hold      <= hold_nxt;
            qph       <= qph_nxt;
            bit_count <= cnt_nxt;
            bit_valid <= bv_nxt;
            bit_out   <= bo_nxt;
            busy      <= busy_nxt;
            done      <= (st_nxt == st_done);
            err       <= (st_nxt == st_err);
        end
    end

endmodule

// File: tb/tb_cw_decoder.sv
// Randomized scoreboard bench for cw_decoder with a registered best_d model and a gap-level decode model.
module tb_cw_decoder;
    localparam int NW = 21;
    localparam int TW = 4;
    localparam int UW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [NW-1:0] n_in = '0;
    logic [TW-1:0] t_in = '0;
    logic [NW-1:0] bd_n;
    logic [TW-1:0] bd_t;
    logic [UW-1:0] bd_u = '0;
    logic [NW-1:0] delta_in = '0;
    logic          delta_valid = 1'b0;
    logic          delta_ready;
    logic          bit_out, bit_valid;
    logic          bit_ready = 1'b1;
    logic          busy, done, err;
    logic [NW-1:0] bit_count;

    cw_decoder #(.NW(NW), .TW(TW), .UW(UW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_in(n_in), .t_in(t_in),
        .bd_n(bd_n), .bd_t(bd_t), .bd_u(bd_u),
        .delta_in(delta_in), .delta_valid(delta_valid), .delta_ready(delta_ready),
        .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .busy(busy), .done(done), .err(err), .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int force_u = -1;
    int rmode = 0;
    int rc = 0;
    bit starve = 1'b0;
    int done_cnt = 0;
    int nseen = 0;
    bit exp_q[$];
    int dq[$];
    int fx[$];

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // best_d stand-in: u = floor(log2((n-t)/t)) capped at 20, or a forced value
    function automatic int ufun(input int n, input int t);
        int q, u;
        if (force_u >= 0) return force_u;
        if (t <= 0 || n <= t) return 0;
        q = (n - t) / t;
        u = 0;
        while (u < 20 && (q >> (u + 1)) != 0) u++;
        return u;
    endfunction

    always @(posedge clk) bd_u <= UW'(ufun(int'(bd_n), int'(bd_t)));

    // sink readiness
    initial forever begin
        @(posedge clk); #1;
        rc++;
        case (rmode)
            1:       bit_ready = 1'($urandom % 2);
            2:       bit_ready = (rc >= 6 && rc < 11) ? 1'b0 : ((rc % 2) == 0);
            default: bit_ready = 1'b1;
        endcase
    end

    // gap source
    initial begin
        bit hs;
        forever begin
            @(negedge clk);
            hs = delta_valid && delta_ready;
            @(posedge clk); #1;
            if (hs && dq.size() > 0) void'(dq.pop_front());
            if (dq.size() > 0 && !starve) begin
                delta_valid = ($urandom % 4) != 0;
                delta_in    = NW'(dq[0]);
            end else begin
                delta_valid = 1'b0;
            end
        end
    end

    // scoreboard monitor
    initial begin
        bit pv, pr, po, e;
        pv = 0; pr = 0; po = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pv && !pr) begin
                    chk("bit_hold_valid", bit_valid, 1);
                    chk("bit_hold_data", bit_out, po);
                end
                if (bit_valid && bit_ready) begin
                    nseen++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL bit_unexpected: got bit %0d with empty scoreboard", bit_out);
                    end else begin
                        e = exp_q.pop_front();
                        if (bit_out !== e) begin
                            errors++;
                            $display("FAIL bit: got %0d expected %0d", bit_out, e);
                        end
                    end
                end
                if (done) done_cnt++;
                pv = bit_valid; pr = bit_ready; po = bit_out;
            end else begin
                pv = 0;
            end
        end
    end

    // gap-level reference: emits 1 per whole d, then 0 and the u-bit remainder
    task automatic build(input int n0, input int t0, output int nb, output int nfin, output bit e);
        int n, t, dl, u, d;
        n = n0; t = t0; nb = 0; e = 0;
        for (int k = 0; k < t0; k++) begin
            dl = (fx.size() > 0) ? fx[k] : int'($urandom_range(n - t, 0));
            dq.push_back(dl);
            if (dl > n - t) begin e = 1; break; end
            u = ufun(n, t); d = 1 << u;
            while (dl >= d) begin
                exp_q.push_back(1'b1); nb++;
                dl -= d; n -= d;
                u = ufun(n, t); d = 1 << u;
            end
            exp_q.push_back(1'b0); nb++;
            for (int b = u - 1; b >= 0; b--) begin
                exp_q.push_back(1'((dl >> b) & 1)); nb++;
            end
            n -= dl + 1;
            t--;
        end
        nfin = n;
    endtask

    task automatic kick(input int n0, input int t0);
        @(posedge clk); #1;
        n_in = NW'(n0); t_in = TW'(t0); start = 1'b1; rc = 0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("err_cleared", err, 0);
        chk("busy_set", busy, 1);
    endtask

    task automatic do_run(input int n0, input int t0, input int rm, input bit stv);
        int nb, nfin, cyc;
        bit e;
        logic [NW-1:0] hn;
        logic [TW-1:0] ht;
        build(n0, t0, nb, nfin, e);
        done_cnt = 0;
        rmode = rm;
        starve = stv;
        kick(n0, t0);
        if (stv) begin
            for (cyc = 0; cyc < 50 && !delta_ready; cyc++) @(negedge clk);
            chk("fetch_reached", delta_ready, 1);
            hn = bd_n; ht = bd_t;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                chk("starve_no_bit", bit_valid, 0);
                chk("starve_bd_n", bd_n, hn);
                chk("starve_bd_t", bd_t, ht);
            end
            starve = 1'b0;
        end
        for (cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            if (done || err) break;
        end
        chk("run_finished", cyc < 20000, 1);
        @(negedge clk);
        chk("err_flag", err, e);
        chk("busy_clear", busy, 0);
        chk("done_pulses", done_cnt, e ? 0 : 1);
        chk("bits_left", exp_q.size(), 0);
        chk("bit_count", bit_count, nb);
        if (!e) begin
            chk("final_n", bd_n, nfin);
            chk("final_t", bd_t, 0);
        end
        dq.delete();
        exp_q.delete();
        rmode = 0;
    endtask

    initial begin
        int cyc;
        #3;
        chk("rst_bit_valid", bit_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_done", done, 0);
        chk("rst_delta_ready", delta_ready, 0);
        chk("rst_bit_count", bit_count, 0);
        chk("rst_bd_n", bd_n, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        fx = {5, 3};  do_run(16, 2, 0, 0);
        force_u = 0;
        fx = {2};     do_run(4, 1, 0, 0);
        force_u = -1;
        fx = {15, 0}; do_run(16, 2, 0, 0);
        fx = {5, 3};  do_run(16, 2, 2, 0);
        fx = {5, 3};  do_run(16, 2, 0, 1);

        // abort after the third bit, then decode again from scratch
        fx = {5, 3};
        begin
            int nb, nfin;
            bit e;
            build(16, 2, nb, nfin, e);
            nseen = 0;
            kick(16, 2);
            for (cyc = 0; cyc < 2000 && nseen < 3; cyc++) @(negedge clk);
            chk("three_bits_seen", nseen >= 3, 1);
            #2 rst_n = 1'b0;
            #1;
            chk("arst_bit_valid", bit_valid, 0);
            chk("arst_bit_out", bit_out, 0);
            chk("arst_busy", busy, 0);
            chk("arst_bit_count", bit_count, 0);
            chk("arst_bd_n", bd_n, 0);
            chk("arst_bd_t", bd_t, 0);
            chk("arst_delta_ready", delta_ready, 0);
            exp_q.delete();
            dq.delete();
            @(negedge clk);
            rst_n = 1'b1;
        end
        fx = {5, 3};  do_run(16, 2, 0, 0);

        fx = {};
        for (int r = 0; r < 10; r++) begin
            int t0, n0;
            t0 = int'($urandom_range(8, 1));
            n0 = t0 + int'($urandom_range(3000, 0));
            do_run(n0, t0, 1, 0);
        end
        do_run(1048576, 8, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cw_decoder.md
Name: cw_decoder

Overview:
- Inverse of the constant-weight encoder path: consumes the t gap values (deltas between successive nonzero positions) of a length-n constant-weight word.
- Regenerates the original binary string as a bit-serial stream, using the same Golomb-like d = 2^u rule as the encoder.
- The u values come from the shared best_d unit, which sits outside this block and is driven through a query port with fixed 1-cycle latency.
- Sits between the CW word deserializer and the message sink in the 20-8 decoder.

Parameters:
- NW, 21, width of n, delta and remaining-length registers.
- TW, 4, width of t.
- UW, 5, width of u (log2 of d).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; loads n_in/t_in; ignored unless IDLE/DONE/ERR
- n_in  input  NW  word length n (e.g. 21'd1048576)
- t_in  input  TW  weight t (1..8)
- bd_n  output  NW  current n presented to best_d
- bd_t  output  TW  current t presented to best_d
- bd_u  input  UW  best_d result; valid exactly 1 cycle after bd_n/bd_t change
- delta_in  input  NW  next gap value
- delta_valid  input  1  delta_in valid
- delta_ready  output  1  block accepts delta_in this cycle
- bit_out  output  1  decoded message bit
- bit_valid  output  1  bit_out valid
- bit_ready  input  1  sink accepts bit_out
- busy  output  1  high from start until DONE/ERR
- done  output  1  one-cycle pulse when t reaches 0
- err  output  1  sticky until next start: delta out of range
- bit_count  output  NW  bits emitted since start

Behaviour:
- Reset (async, rst_n=0): state=IDLE; bd_n=0, bd_t=0, delta_ready=0, bit_out=0, bit_valid=0, busy=0, done=0, err=0, bit_count=0. Internal n/t/delta/u registers cleared.
- Reset asserted mid-operation aborts immediately; no done pulse; a partial bit stream is discarded by the sink.
- States:
  - IDLE: on start, load n=n_in, t=t_in, bit_count=0, err=0, busy=1. Go to DONE if t_in==0, else QUERY.
  - QUERY: drive bd_n=n, bd_t=t. Wait exactly 1 cycle, then latch u=bd_u and d=1<<u. Go to FETCH if no delta is held, else CMP.
  - FETCH: delta_ready=1. On delta_valid&&delta_ready:
    - if delta_in > n-t: set err, go to ERR;
    - else hold delta and go to CMP.
  - CMP: if delta >= d, go to EMIT1; else go to EMIT0.
  - EMIT1: present bit 1. On handshake: delta-=d, n-=d, go to QUERY (the held delta is kept).
  - EMIT0: present bit 0. On handshake: if u==0 go to COMMIT, else go to EMITB with idx=u-1.
  - EMITB: present bit_out=delta[idx], sending u bits MSB first. On handshake: if idx==0 go to COMMIT, else idx-=1.
  - COMMIT: n-=delta+1, t-=1, release the delta. Go to DONE if t==0, else QUERY. Takes one cycle.
  - DONE: pulse done for 1 cycle, busy=0, then IDLE.
  - ERR: busy=0, err stays 1; exit only on start (or reset).
- Bit handshake:
  - bit_valid is registered.
  - bit_out is stable while bit_valid && !bit_ready.
  - A transfer occurs on bit_valid&&bit_ready.
  - bit_count increments on each transfer and wraps modulo 2^NW, with no flag.
- delta_ready is high only in FETCH and only one delta is accepted per FETCH; deltas arriving in other states stall.
- Arithmetic: all unsigned, NW bits. The range check guarantees n never underflows. u up to 20 gives d=2^20, which fits in NW.
- start while busy: ignored.

Test Plan:
- Basic decode. n=16, t=2; bench best_d model returns u=2, 2, 3 in sequence; deltas 5, 3.
  -> Bits 1,0,0,1,0,0,1,1; done pulses once; bit_count=8; final internal n=6, t=0.
- u=0 path. n=4, t=1; model u=0; delta=2.
  -> Bits 1,1,0; done; bit_count=3.
- Range error. n=16, t=2; delta=15 (>14).
  -> err=1, busy=0, no bits emitted, done never pulses; a following start clears err.
- Backpressure. Repeat the basic decode with bit_ready toggling 1010... and held low for 5 cycles mid-stream.
  -> Identical bit sequence; bit_out stable whenever bit_valid && !bit_ready.
- Delta starvation and latency. Hold delta_valid low for 10 cycles in FETCH.
  -> No bit_valid meanwhile; bd_n/bd_t are stable; bd_u is sampled exactly 1 cycle after a query.
- Reset mid-stream. Assert rst_n=0 after the 3rd bit of the basic decode.
  -> All outputs at reset values asynchronously; a fresh start re-decodes correctly from bit 0.
